culsans_exit_monitor: RTL
=========================

# culsans_exit_monitor

Synthesizable, parametrised end-of-run monitor for the multicore Culsans system. It generalises the single 32-bit tohost check to `NumCores` independent exit channels, with sticky per-core code capture, a configurable completion mode, a cycle watchdog and an aggregated pass/fail verdict. It sits beside `ariane_ccu_multicore_top`, usable both in the integration bench and in FPGA builds driving status LEDs/UART.

## Interface
- `NumCores`, default 2: number of exit channels; must be ≥1.
- `ExitWidth`, default 32: width of each channel; bit 0 = exit strobe, `[ExitWidth-1:1]` = return code.
- `WaitAll`, default 1'b1: 1 = run completes when every core has exited; 0 = first exit completes the run.
- `TimeoutCycles`, default 32'd0: watchdog limit in cycles; 0 disables the watchdog.
- `CntWidth`, default 32: width of the cycle counter.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `exit_i`  in  `NumCores`×`ExitWidth`  per-core tohost words.
- `clear_i`  in  1  synchronous restart of a new run; ignored while `rst_ni`=0.
- `exited_o`  out  `NumCores`  sticky per-core exit-captured flags.
- `done_o`  out  1  run finished (completion or timeout); sticky.
- `pass_o`  out  1  `done_o` && no timeout && all captured codes zero.
- `fail_o`  out  1  `done_o` && (timeout || any captured code nonzero).
- `timeout_o`  out  1  run ended by watchdog.
- `fail_core_o`  out  `max(1,$clog2(NumCores))`  lowest-index core with nonzero captured code; 0 if none.
- `fail_code_o`  out  `ExitWidth-1`  captured code of `fail_core_o`; 0 if none.
- `cycles_o`  out  `CntWidth`  cycles spent in RUN, saturating.

## Operation
- States: RUN, DONE. Reset and `clear_i` → RUN with all captures, flags, counter and outputs cleared.
- RUN: for each core with `exited_o[i]`=0 and `exit_i[i][0]`=1, latch `exit_i[i][ExitWidth-1:1]` and set `exited_o[i]`. Capture is first-write-wins; later changes on `exit_i[i]` are ignored until clear.
- Completion condition evaluated on the post-capture flags: `WaitAll`=1 → all `exited_o` set; `WaitAll`=0 → any set.
- Completion → DONE; `pass_o`/`fail_o` computed from captured codes of exited cores only (non-exited cores in first-exit mode contribute nothing).
- Watchdog: counter increments every RUN cycle, saturating at all-ones. If `TimeoutCycles`≠0 and counter reaches `TimeoutCycles-1` while not completing → DONE with `timeout_o`=1, `fail_o`=1. Captures made in that same cycle are still recorded.
- Simultaneous completion and timeout in one cycle: completion wins, `timeout_o`=0.
- Multiple cores exiting in the same cycle: all captured; `fail_core_o` selects lowest failing index.
- DONE: no captures, counter frozen, outputs held until `clear_i` or reset.
- `clear_i` in RUN restarts immediately (counter to 0, captures dropped).

## Timing
- All outputs registered; every output resets to 0.
- Capture latency 1 cycle: `exit_i[i][0]` high at edge N → `exited_o[i]`=1 after edge N.
- `done_o`/`pass_o`/`fail_o`/`fail_core_o`/`fail_code_o` valid in the same cycle `exited_o` completes (computed from next-state captures), i.e. 1 cycle after the completing strobe.
- `cycles_o` = number of RUN edges elapsed; equals `TimeoutCycles` in the cycle `timeout_o` rises.
- `clear_i` and reset take effect at the next edge; reset has priority over `clear_i`.
- `exit_i` is assumed synchronous to `clk_i`; no internal synchroniser.

## Structure
- `culsans_pkg`: `exit_state_e` (RUN, DONE), helper function `exit_strobe(word)`/`exit_code(word)`.
- Sub-module `culsans_exit_capture`: one per core (generate loop), holds sticky flag + code, inputs strobe/code/enable/clear.
- Top: FSM, counter, lowest-index fail priority encoder, verdict registers.

## Test plan
- `NumCores`=2, `WaitAll`=1: core0 writes 0x1 at cycle 10, core1 0x1 at cycle 20 → `done_o`,`pass_o`=1 after cycle-20 edge, `cycles_o`=21.
- `WaitAll`=1: core1 writes 0x7 (code 3), core0 writes 0x1 same cycle → `fail_o`=1, `fail_core_o`=1, `fail_code_o`=3.
- `WaitAll`=0, `NumCores`=4: core2 writes 0x5 → `done_o`,`fail_o`, `fail_core_o`=2, `fail_code_o`=2; later core0 write ignored.
- `TimeoutCycles`=100, no exits → `timeout_o`,`fail_o`=1 with `cycles_o`=100; completing strobe on that exact cycle → `pass_o`=1, `timeout_o`=0.
- Core0 writes 0x3 then 0x1 → `fail_code_o` stays 1 (first-write-wins).
- Mid-run `clear_i` after one capture, then reset asserted while `clear_i`=1 → all outputs 0, new run counts from 0.

Source files
------------

// File: rtl/culsans_pkg.sv
// Shared types and tohost-word helpers for the Culsans exit monitor.
package culsans_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } exit_state_e;

  // Widest tohost word the helpers accept; narrower words are zero-extended by the caller.
  localparam int unsigned MaxExitWidth = 64;

  typedef logic [MaxExitWidth-1:0] exit_word_t;

  // Bit 0 of a tohost word is the exit strobe.
  function automatic logic exit_strobe(input exit_word_t word);
    return word[0];
  endfunction

  // Everything above the strobe bit is the return code.
  function automatic logic [MaxExitWidth-2:0] exit_code(input exit_word_t word);
    return word[MaxExitWidth-1:1];
  endfunction

endpackage

// File: rtl/culsans_exit_capture.sv
// Sticky first-write-wins capture of one core's exit strobe and return code.
module culsans_exit_capture
  import culsans_pkg::*;
#(
  parameter int unsigned CodeWidth = 31
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic                 strobe_i,
  input  logic [CodeWidth-1:0] code_i,
  output logic                 exited_o,
  output logic                 exited_d_o,
  output logic [CodeWidth-1:0] code_d_o
);

  logic                 exited_q, exited_d;
  logic [CodeWidth-1:0] code_q, code_d;

  // Latch the first strobe while enabled; clear drops any capture.
  always_comb begin
    exited_d = exited_q;
    code_d   = code_q;
    if (clear_i) begin
      exited_d = 1'b0;
      code_d   = '0;
    end else if (en_i && !exited_q && strobe_i) begin
      exited_d = 1'b1;
      code_d   = code_i;
    end
  end

  // Capture registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      exited_q <= 1'b0;
      code_q   <= '0;
    end else begin
      exited_q <= exited_d;
      code_q   <= code_d;
    end
  end

  // The top judges completion on next-state captures so the verdict lands with the flag.
  assign exited_o   = exited_q;
  assign exited_d_o = exited_d;
  assign code_d_o   = code_d;

endmodule

// File: rtl/culsans_exit_monitor.sv
// End-of-run monitor: per-core exit capture, completion/watchdog FSM, aggregated verdict.
//
// State | Meaning
// RUN   | capturing exits, counting cycles, watching for completion or watchdog expiry
// DONE  | run over; captures, counter and verdict frozen until clear or reset
module culsans_exit_monitor
  import culsans_pkg::*;
#(
  parameter int unsigned NumCores      = 2,
  parameter int unsigned ExitWidth     = 32,
  parameter bit          WaitAll       = 1'b1,
  parameter logic [31:0] TimeoutCycles = 32'd0,
  parameter int unsigned CntWidth      = 32,
  localparam int unsigned CoreIdxW     = (NumCores > 1) ? $clog2(NumCores) : 1,
  localparam int unsigned CodeW        = ExitWidth - 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumCores-1:0][ExitWidth-1:0] exit_i,
  input  logic                               clear_i,
  output logic [NumCores-1:0]                exited_o,
  output logic                               done_o,
  output logic                               pass_o,
  output logic                               fail_o,
  output logic                               timeout_o,
  output logic [CoreIdxW-1:0]                fail_core_o,
  output logic [CodeW-1:0]                   fail_code_o,
  output logic [CntWidth-1:0]                cycles_o
);

  localparam bit                TmoEn   = (TimeoutCycles != 32'd0);
  localparam logic [CntWidth-1:0] TmoLast = CntWidth'(TimeoutCycles - 32'd1);

  exit_state_e               state_q, state_d;
  logic                      done_q, done_d, pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d;
  logic [CoreIdxW-1:0]       fcore_q, fcore_d;
  logic [CodeW-1:0]          fcode_q, fcode_d;
  logic [CntWidth-1:0]       cnt_q, cnt_d;

  logic                      capture_en;
  logic [NumCores-1:0]       exited_nxt;
  logic [NumCores-1:0][CodeW-1:0] code_nxt;
  logic                      complete, tmo_hit, fail_any;
  logic [CoreIdxW-1:0]       fcore_sel;
  logic [CodeW-1:0]          fcode_sel;

  assign capture_en = (state_q == RUN);

  for (genvar g = 0; g < NumCores; g++) begin : g_core
    culsans_exit_capture #(
      .CodeWidth(CodeW)
    ) u_capture (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_i       (capture_en),
      .clear_i    (clear_i),
      .strobe_i   (exit_strobe(MaxExitWidth'(exit_i[g]))),
      .code_i     (CodeW'(exit_code(MaxExitWidth'(exit_i[g])))),
      .exited_o   (exited_o[g]),
      .exited_d_o (exited_nxt[g]),
      .code_d_o   (code_nxt[g])
    );
  end

  // Lowest-index core with a nonzero captured code; scanning downward lets the lowest win.
  always_comb begin
    fail_any  = 1'b0;
    fcore_sel = '0;
    fcode_sel = '0;
    for (int i = int'(NumCores) - 1; i >= 0; i--) begin
      if (exited_nxt[i] && (code_nxt[i] != '0)) begin
        fail_any  = 1'b1;
        fcore_sel = CoreIdxW'(i);
        fcode_sel = code_nxt[i];
      end
    end
  end

  // Completion uses post-capture flags; the watchdog fires on the last counted cycle.
  always_comb begin
    complete = WaitAll ? (&exited_nxt) : (|exited_nxt);
    tmo_hit  = TmoEn && (cnt_q == TmoLast);
  end

  // Next-state for FSM, counter and verdict; completion beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
    fcore_d = fcore_q;
    fcode_d = fcode_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      state_d = RUN;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      tmo_d   = 1'b0;
      fcore_d = '0;
      fcode_d = '0;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + CntWidth'(1);
      if (complete || tmo_hit) begin
        state_d = DONE;
        done_d  = 1'b1;
        tmo_d   = !complete;
        pass_d  = complete && !fail_any;
        fail_d  = !complete || fail_any;
        fcore_d = fcore_sel;
        fcode_d = fcode_sel;
      end
    end
  end

  // FSM state and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RUN;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
      fcore_q <= '0;
      fcode_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
      fcore_q <= fcore_d;
      fcode_q <= fcode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign timeout_o   = tmo_q;
  assign fail_core_o = fcore_q;
  assign fail_code_o = fcode_q;
  assign cycles_o    = cnt_q;

endmodule
